// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction fields and ALU flag in, datapath control strobes out.
interface alu_seq_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
    logic       opcode_err;

    modport master (
        input  opcode, funct, alu_zero,
        output alu_src_a, alu_src_b, alu_op, mem_read, ir_write, pc_write, pc_src,
               aluout_write, reg_write, reg_dst, instr_done, opcode_err
    );

    modport slave (
        output opcode, funct, alu_zero,
        input  alu_src_a, alu_src_b, alu_op, mem_read, ir_write, pc_write, pc_src,
               aluout_write, reg_write, reg_dst, instr_done, opcode_err
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multicycle fetch/decode/execute/write-back sequencer for add/sub/and/addi/beq/bne.
module alu_seq_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WB, S_ILLEGAL} state_t;
    typedef enum logic [2:0] {K_ADD, K_SUB, K_AND, K_ADDI, K_BEQ, K_BNE} kind_t;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       aluout_write;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       opcode_err;
    } ctrl_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t state_q, state_d;
    kind_t  kind_q, kind_d, dec_kind;
    logic [2:0] cnt_q, cnt_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   hold_q;
    logic   dec_ok, is_r, fetch_last, br_take;
    logic   st_dec, st_exec, st_wb, st_ill, exec_br;

    always_comb begin
        is_r     = bus.opcode == 6'h00;
        dec_ok   = is_r ? (bus.funct == 6'h20 || bus.funct == 6'h22 || bus.funct == 6'h24)
                        : (bus.opcode == 6'h08 || bus.opcode == 6'h04 || bus.opcode == 6'h05);
        dec_kind = is_r ? (bus.funct == 6'h22 ? K_SUB : bus.funct == 6'h24 ? K_AND : K_ADD)
                        : (bus.opcode == 6'h08 ? K_ADDI : bus.opcode == 6'h04 ? K_BEQ : K_BNE);
    end

    // hold_q keeps one full RESET cycle after reset drops before fetching
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        case (state_q)
            S_RESET: begin
                state_d = hold_q ? S_RESET : S_FETCH;
                cnt_d   = 3'd0;
            end
            S_FETCH: begin
                state_d = cnt_q == WAIT_LAST ? S_DECODE : S_FETCH;
                cnt_d   = cnt_q == WAIT_LAST ? 3'd0 : cnt_q + 3'd1;
            end
            S_DECODE: begin
                kind_d  = dec_kind;
                state_d = dec_ok ? S_EXEC : S_ILLEGAL;
            end
            S_EXEC:  state_d = (kind_q == K_BEQ || kind_q == K_BNE) ? S_FETCH : S_WB;
            default: state_d = S_FETCH;
        endcase
    end

    // outputs for the upcoming cycle are decoded from next state and registered
    always_comb begin
        fetch_last = state_d == S_FETCH && cnt_d == WAIT_LAST;
        st_dec     = state_d == S_DECODE;
        st_exec    = state_d == S_EXEC;
        st_wb      = state_d == S_WB;
        st_ill     = state_d == S_ILLEGAL;
        exec_br    = st_exec && (kind_d == K_BEQ || kind_d == K_BNE);
        ctrl_d              = '0;
        ctrl_d.mem_read     = state_d == S_FETCH;
        ctrl_d.ir_write     = fetch_last;
        ctrl_d.pc_write     = fetch_last;
        ctrl_d.alu_src_a    = st_exec;
        ctrl_d.alu_src_b    = fetch_last ? 2'b01 : st_dec ? 2'b11
                            : (st_exec && kind_d == K_ADDI) ? 2'b10 : 2'b00;
        ctrl_d.alu_op       = (fetch_last || st_dec) ? 3'b001 : !st_exec ? 3'b000
                            : (exec_br || kind_d == K_SUB) ? 3'b010
                            : kind_d == K_AND ? 3'b011 : 3'b001;
        ctrl_d.pc_src       = exec_br;
        ctrl_d.aluout_write = st_dec || (st_exec && !exec_br);
        ctrl_d.reg_write    = st_wb;
        ctrl_d.reg_dst      = st_wb && (kind_d == K_ADD || kind_d == K_SUB || kind_d == K_AND);
        ctrl_d.instr_done   = st_wb || st_ill || exec_br;
        ctrl_d.opcode_err   = st_ill;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= 3'd0;
            kind_q  <= K_ADD;
            ctrl_q  <= '0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            ctrl_q  <= ctrl_d;
            hold_q  <= 1'b0;
        end
    end

    // branch decision is the only output that follows alu_zero within the cycle
    assign br_take = state_q == S_EXEC &&
                     (kind_q == K_BEQ ? bus.alu_zero : (kind_q == K_BNE && !bus.alu_zero));

    assign bus.alu_src_a    = ctrl_q.alu_src_a;
    assign bus.alu_src_b    = ctrl_q.alu_src_b;
    assign bus.alu_op       = ctrl_q.alu_op;
    assign bus.mem_read     = ctrl_q.mem_read;
    assign bus.ir_write     = ctrl_q.ir_write;
    assign bus.pc_write     = ctrl_q.pc_write | br_take;
    assign bus.pc_src       = ctrl_q.pc_src;
    assign bus.aluout_write = ctrl_q.aluout_write;
    assign bus.reg_write    = ctrl_q.reg_write;
    assign bus.reg_dst      = ctrl_q.reg_dst;
    assign bus.instr_done   = ctrl_q.instr_done;
    assign bus.opcode_err   = ctrl_q.opcode_err;

    a_ir_reg: assert property (@(posedge clk) !(bus.ir_write && bus.reg_write));
    a_pcsrc:  assert property (@(posedge clk) !(bus.pc_write && bus.pc_src && state_q != S_EXEC));
    a_srcb11: assert property (@(posedge clk) bus.alu_src_b != 2'b11 || state_q == S_DECODE);
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vector table plus hand sequences for reset and MEM_WAIT=0.
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst2, rst0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if b2();
    alu_seq_ctrl_if b0();

    alu_seq_ctrl #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(rst2), .bus(b2));
    alu_seq_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(rst0), .bus(b0));

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int cyc, sa, sb, aop, pcw, pcs, aw, rw, rd, err;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs2();
        return int'({b2.alu_src_a, b2.alu_src_b, b2.alu_op, b2.mem_read, b2.ir_write,
                     b2.pc_write, b2.pc_src, b2.aluout_write, b2.reg_write, b2.reg_dst,
                     b2.instr_done, b2.opcode_err});
    endfunction

    // called at the negedge of the first FETCH cycle; returns at the next one
    task automatic run_vec(input vec_t v);
        int n, mr, rw, rd, err, irw, dsb, sa, sb, aop, pcw, pcs, aw;
        bit done;
        b2.opcode = v.op;
        b2.funct = v.fn;
        b2.alu_zero = v.z;
        n = 0; mr = 0; rw = 0; rd = 0; err = 0; irw = 0; dsb = 0;
        sa = 0; sb = 0; aop = 0; pcw = 0; pcs = 0; aw = 0;
        done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (i > 0) @(negedge clk);
            n++;
            mr += int'(b2.mem_read);
            rw += int'(b2.reg_write);
            err += int'(b2.opcode_err);
            if (b2.reg_write) rd = int'(b2.reg_dst);
            if (i == 2) irw = int'(b2.ir_write);
            if (i == 3) dsb = int'(b2.alu_src_b);
            if (i == 4) begin
                sa = int'(b2.alu_src_a); sb = int'(b2.alu_src_b); aop = int'(b2.alu_op);
                pcw = int'(b2.pc_write); pcs = int'(b2.pc_src); aw = int'(b2.aluout_write);
            end
            done = b2.instr_done;
        end
        chk({v.nm, " cycles"}, n, v.cyc);
        chk({v.nm, " mem_read_cycles"}, mr, 3);
        chk({v.nm, " ir_write"}, irw, 1);
        chk({v.nm, " decode_src_b"}, dsb, 3);
        chk({v.nm, " exec_src_a"}, sa, v.sa);
        chk({v.nm, " exec_src_b"}, sb, v.sb);
        chk({v.nm, " exec_alu_op"}, aop, v.aop);
        chk({v.nm, " exec_pc_write"}, pcw, v.pcw);
        chk({v.nm, " exec_pc_src"}, pcs, v.pcs);
        chk({v.nm, " exec_aluout_write"}, aw, v.aw);
        chk({v.nm, " reg_write"}, rw, v.rw);
        chk({v.nm, " reg_dst"}, rd, v.rd);
        chk({v.nm, " opcode_err"}, err, v.err);
        @(negedge clk);
        chk({v.nm, " next_fetch"}, int'(b2.mem_read), 1);
        chk({v.nm, " done_not_repeated"}, int'(b2.instr_done), 0);
    endtask

    initial begin
        int n, rws;
        bit done;
        vt[0] = '{"add",     6'h00, 6'h20, 1'b0, 6, 1, 0, 1, 0, 0, 1, 1, 1, 0};
        vt[1] = '{"sub",     6'h00, 6'h22, 1'b0, 6, 1, 0, 2, 0, 0, 1, 1, 1, 0};
        vt[2] = '{"and",     6'h00, 6'h24, 1'b1, 6, 1, 0, 3, 0, 0, 1, 1, 1, 0};
        vt[3] = '{"addi",    6'h08, 6'h3f, 1'b0, 6, 1, 2, 1, 0, 0, 1, 1, 0, 0};
        vt[4] = '{"beq_z1",  6'h04, 6'h00, 1'b1, 5, 1, 0, 2, 1, 1, 0, 0, 0, 0};
        vt[5] = '{"beq_z0",  6'h04, 6'h00, 1'b0, 5, 1, 0, 2, 0, 1, 0, 0, 0, 0};
        vt[6] = '{"bne_z1",  6'h05, 6'h00, 1'b1, 5, 1, 0, 2, 0, 1, 0, 0, 0, 0};
        vt[7] = '{"bne_z0",  6'h05, 6'h00, 1'b0, 5, 1, 0, 2, 1, 1, 0, 0, 0, 0};
        vt[8] = '{"ill_op23", 6'h23, 6'h20, 1'b0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[9] = '{"ill_fn25", 6'h00, 6'h25, 1'b0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        rst2 = 1'b1;
        rst0 = 1'b1;
        b2.opcode = 6'h00; b2.funct = 6'h20; b2.alu_zero = 1'b0;
        b0.opcode = 6'h00; b0.funct = 6'h20; b0.alu_zero = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_held_outputs", outs2(), 0);
        end
        rst2 = 1'b0;
        @(negedge clk);
        chk("reset_cycle_outputs", outs2(), 0);
        @(negedge clk);
        chk("first_fetch_mem_read", int'(b2.mem_read), 1);

        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        b2.opcode = 6'h00; b2.funct = 6'h20; b2.alu_zero = 1'b0;
        rws = int'(b2.reg_write);
        repeat (4) begin
            @(negedge clk);
            rws += int'(b2.reg_write);
        end
        chk("midrst_in_exec", int'(b2.alu_src_a), 1);
        rst2 = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", outs2(), 0);
        rst2 = 1'b0;
        @(negedge clk);
        chk("midrst_reset_cycle", outs2(), 0);
        chk("midrst_no_reg_write", rws, 0);
        @(negedge clk);
        chk("midrst_refetch", int'(b2.mem_read), 1);
        chk("midrst_cnt0_no_ir", int'(b2.ir_write), 0);
        @(negedge clk);
        chk("midrst_cnt1_no_ir", int'(b2.ir_write), 0);
        @(negedge clk);
        chk("midrst_cnt2_ir", int'(b2.ir_write), 1);
        repeat (3) @(negedge clk);
        chk("midrst_wb_reg_write", int'(b2.reg_write), 1);
        chk("midrst_wb_done", int'(b2.instr_done), 1);

        rst0 = 1'b0;
        @(negedge clk);
        chk("mw0_reset_cycle", int'(b0.mem_read), 0);
        @(negedge clk);
        chk("mw0_fetch_mem_read", int'(b0.mem_read), 1);
        chk("mw0_fetch_ir_write", int'(b0.ir_write), 1);
        chk("mw0_fetch_src_b", int'(b0.alu_src_b), 1);
        n = 0;
        done = 0;
        rws = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (i > 0) @(negedge clk);
            n++;
            rws += int'(b0.reg_write);
            if (i == 1) chk("mw0_decode_src_b", int'(b0.alu_src_b), 3);
            done = b0.instr_done;
        end
        chk("mw0_cycles", n, 4);
        chk("mw0_reg_write", rws, 1);
        @(negedge clk);
        chk("mw0_next_fetch", int'(b0.mem_read), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
